// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer
//   Power-on initialiser and byte-write engine for a 4-bit character LCD.
//   After reset it waits out the power-up delay and sends the 0x3,0x3,0x3,0x2
//   init nibbles. It then writes the configuration bytes 0x28, 0x06, 0x0C and
//   0x01, and from then on accepts client bytes over a valid/ready handshake.
//   Each byte goes out as an upper and a lower nibble strobe. The settle time
//   that byte needs is enforced before the next byte is accepted.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  client handshake; a byte is taken on valid && ready
//   req_rs, req_data     0 = command / 1 = character, byte to write
//   init_done            high once the init and configuration sequence is done
//   LCD_E, LCD_RS,       LCD enable strobe, register select,
//   LCD_RW               read/write (tied to write)
//   SF_D11..SF_D8        data nibble, SF_D11 = MSB
module lcd_write_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_E       = 12,
  parameter int unsigned T_NIB     = 50,
  parameter int unsigned CW        = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       SF_D11,
  output logic       SF_D10,
  output logic       SF_D9,
  output logic       SF_D8
);

  localparam logic [2:0] PWR_WAIT  = 3'd0;
  localparam logic [2:0] INIT      = 3'd1;
  localparam logic [2:0] CFG       = 3'd2;
  localparam logic [2:0] IDLE      = 3'd3;
  localparam logic [2:0] BYTE_HI   = 3'd4;
  localparam logic [2:0] BYTE_LO   = 3'd5;
  localparam logic [2:0] BYTE_WAIT = 3'd6;

  // The lower-nibble slot is split in two. BYTE_LO covers the strobe and
  // BYTE_WAIT covers the rest of the settle time, so the two together last
  // exactly W cycles from the lower-nibble start.
  localparam logic [CW-1:0] PWR_LAST   = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] INIT1_LAST = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] INIT2_LAST = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] NIB_LAST   = CW'(T_NIB - 1);
  localparam logic [CW-1:0] LO_LAST    = CW'(T_E + 1);
  localparam logic [CW-1:0] WCMD_LAST  = CW'(T_CMD - T_E - 3);
  localparam logic [CW-1:0] WCLR_LAST  = CW'(T_CLEAR - T_E - 3);
  localparam logic [CW-1:0] E_FIRST    = CW'(2);
  localparam logic [CW-1:0] E_LAST     = CW'(T_E + 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    init_step, init_step_n;
  logic [1:0]    cfg_idx, cfg_idx_n;
  logic          byte_rs, byte_rs_n;
  logic [7:0]    byte_data, byte_data_n;
  logic [3:0]    sf_d, sf_d_n;
  logic          rs_n, done_n, e_n;
  logic [CW-1:0] init_last, wait_last;
  logic [7:0]    cfg_byte;

  always_comb begin
    case (init_step)
      2'd0:    init_last = INIT1_LAST;
      2'd1:    init_last = INIT2_LAST;
      default: init_last = CMD_LAST;
    endcase
    case (cfg_idx)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
    // Clear/home commands need the long settle time.
    if (!byte_rs && (byte_data == 8'h01 || byte_data == 8'h02 || byte_data == 8'h03))
      wait_last = WCLR_LAST;
    else
      wait_last = WCMD_LAST;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CW'(1);
    init_step_n = init_step;
    cfg_idx_n   = cfg_idx;
    byte_rs_n   = byte_rs;
    byte_data_n = byte_data;
    sf_d_n      = sf_d;
    rs_n        = LCD_RS;
    done_n      = init_done;
    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_n     = INIT;
          cnt_n       = '0;
          init_step_n = '0;
          sf_d_n      = 4'h3;
          rs_n        = 1'b0;
        end
      end
      INIT: begin
        if (cnt == init_last) begin
          cnt_n = '0;
          if (init_step == 2'd3) begin
            state_n   = CFG;
            cfg_idx_n = '0;
          end else begin
            init_step_n = init_step + 2'd1;
            sf_d_n      = (init_step == 2'd2) ? 4'h2 : 4'h3;
            rs_n        = 1'b0;
          end
        end
      end
      CFG: begin
        state_n     = BYTE_HI;
        cnt_n       = '0;
        byte_rs_n   = 1'b0;
        byte_data_n = cfg_byte;
        sf_d_n      = cfg_byte[7:4];
        rs_n        = 1'b0;
      end
      IDLE: begin
        cnt_n = '0;
        if (req_valid && req_ready) begin
          state_n     = BYTE_HI;
          byte_rs_n   = req_rs;
          byte_data_n = req_data;
          sf_d_n      = req_data[7:4];
          rs_n        = req_rs;
        end
      end
      BYTE_HI: begin
        if (cnt == NIB_LAST) begin
          state_n = BYTE_LO;
          cnt_n   = '0;
          sf_d_n  = byte_data[3:0];
        end
      end
      BYTE_LO: begin
        if (cnt == LO_LAST) begin
          state_n = BYTE_WAIT;
          cnt_n   = '0;
        end
      end
      BYTE_WAIT: begin
        if (cnt == wait_last) begin
          cnt_n = '0;
          if (init_done) begin
            state_n = IDLE;
          end else if (cfg_idx == 2'd3) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n   = CFG;
            cfg_idx_n = cfg_idx + 2'd1;
          end
        end
      end
      default: begin
        state_n = PWR_WAIT;
        cnt_n   = '0;
      end
    endcase
    // E is derived from the next slot position so that it is registered with
    // the same edge that advances the counter.
    e_n = (state_n == INIT || state_n == BYTE_HI || state_n == BYTE_LO) &&
          (cnt_n >= E_FIRST) && (cnt_n <= E_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      init_step <= '0;
      cfg_idx   <= '0;
      byte_rs   <= 1'b0;
      byte_data <= '0;
      sf_d      <= '0;
      LCD_RS    <= 1'b0;
      LCD_E     <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      init_step <= init_step_n;
      cfg_idx   <= cfg_idx_n;
      byte_rs   <= byte_rs_n;
      byte_data <= byte_data_n;
      sf_d      <= sf_d_n;
      LCD_RS    <= rs_n;
      LCD_E     <= e_n;
      req_ready <= (state_n == IDLE);
      init_done <= done_n;
    end
  end

  assign LCD_RW = 1'b0;
  assign SF_D11 = sf_d[3];
  assign SF_D10 = sf_d[2];
  assign SF_D9  = sf_d[1];
  assign SF_D8  = sf_d[0];

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer
//   Directed bench for lcd_write_sequencer. It uses scaled-down delays so the
//   whole run stays short. Expected strobe times are derived from those delays.
module tb_lcd_write_sequencer;

  localparam int P_PWR = 1000;
  localparam int P_I1  = 400;
  localparam int P_I2  = 100;
  localparam int P_CMD = 200;
  localparam int P_CLR = 600;
  localparam int P_E   = 12;
  localparam int P_NIB = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       init_done;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic       SF_D11, SF_D10, SF_D9, SF_D8;

  lcd_write_sequencer #(
    .T_POWERUP(P_PWR), .T_INIT1(P_I1), .T_INIT2(P_I2), .T_CMD(P_CMD),
    .T_CLEAR(P_CLR), .T_E(P_E), .T_NIB(P_NIB), .CW(24)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_data(req_data), .init_done(init_done),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .SF_D11(SF_D11), .SF_D10(SF_D10), .SF_D9(SF_D9), .SF_D8(SF_D8)
  );

  always #5 clk = ~clk;

  // Cycle index: 0 is the first cycle after the last reset edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // E pulse log: start cycle, width, nibble and RS at the rising edge.
  int         p_start [64];
  int         p_width [64];
  logic [3:0] p_nib   [64];
  logic       p_rs    [64];
  int         np = 0;
  logic       e_prev = 1'b0;
  logic       early_ready = 1'b0;
  logic       rw_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (LCD_RW !== 1'b0) rw_seen = 1'b1;
    if (req_ready && !init_done) early_ready = 1'b1;
    if (LCD_E && !e_prev && np < 64) begin
      p_start[np] = cyc;
      p_nib[np]   = {SF_D11, SF_D10, SF_D9, SF_D8};
      p_rs[np]    = LCD_RS;
      p_width[np] = 0;
      np++;
    end
    if (!LCD_E && e_prev && np > 0) p_width[np-1] = cyc - p_start[np-1];
    e_prev = LCD_E;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int t);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rs = rs; req_data = d;
    while (!req_ready && n < 5000) begin @(negedge clk); n++; end
    check("accept_in_time", {31'd0, req_ready}, 32'd1);
    t = cyc;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the byte must already be latched.
    req_valid = 1'b0; req_rs = ~rs; req_data = ~d;
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 5000) begin @(negedge clk); n++; end
    check("ready_in_time", {31'd0, req_ready}, 32'd1);
    rc = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] cfg_bytes [4];
  logic [7:0] bb        [3];
  logic [7:0] wd        [4];
  logic       wr        [4];
  int         ww        [4];

  initial begin
    int t, rc, base, n, e0, e1, e2, e3, done_cyc;
    int acc [3];
    cfg_bytes[0] = 8'h28; cfg_bytes[1] = 8'h06; cfg_bytes[2] = 8'h0C; cfg_bytes[3] = 8'h01;
    bb[0] = 8'h5A; bb[1] = 8'hC3; bb[2] = 8'h7E;
    wr[0] = 1'b0; wd[0] = 8'h01; ww[0] = P_CLR;
    wr[1] = 1'b1; wd[1] = 8'h01; ww[1] = P_CMD;
    wr[2] = 1'b0; wd[2] = 8'h03; ww[2] = P_CLR;
    wr[3] = 1'b0; wd[3] = 8'h04; ww[3] = P_CMD;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_E", {31'd0, LCD_E}, 32'd0);
    check("rst_RS", {31'd0, LCD_RS}, 32'd0);
    check("rst_RW", {31'd0, LCD_RW}, 32'd0);
    check("rst_D", {28'd0, SF_D11, SF_D10, SF_D9, SF_D8}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;

    // Power-up, init nibbles and configuration bytes.
    n = 0;
    while (!init_done && n < 6000) begin @(negedge clk); n++; end
    check("init_done_in_time", {31'd0, init_done}, 32'd1);
    done_cyc = cyc;
    check("ready_at_done", {31'd0, req_ready}, 32'd1);
    check("init_pulse_count", np, 12);
    e0 = P_PWR + 2; e1 = e0 + P_I1; e2 = e1 + P_I2; e3 = e2 + P_CMD;
    check("init0_start", p_start[0], e0);
    check("init1_start", p_start[1], e1);
    check("init2_start", p_start[2], e2);
    check("init3_start", p_start[3], e3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init%0d_nib", i), {28'd0, p_nib[i]}, (i == 3) ? 32'h2 : 32'h3);
      check($sformatf("init%0d_width", i), p_width[i], P_E);
      check($sformatf("init%0d_rs", i), {31'd0, p_rs[i]}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cfg%0d_hi_nib", k), {28'd0, p_nib[4+2*k]}, {28'd0, cfg_bytes[k][7:4]});
      check($sformatf("cfg%0d_lo_nib", k), {28'd0, p_nib[5+2*k]}, {28'd0, cfg_bytes[k][3:0]});
      check($sformatf("cfg%0d_lo_delay", k), p_start[5+2*k] - p_start[4+2*k], P_NIB);
      check($sformatf("cfg%0d_rs", k), {30'd0, p_rs[4+2*k], p_rs[5+2*k]}, 32'd0);
    end
    check("cfg0_after_init", {31'd0, p_start[4] >= e3 + P_CMD}, 32'd1);
    check("done_after_clear", done_cyc, p_start[11] - 2 + P_CLR);

    // Data write 'A'.
    base = np;
    send(1'b1, 8'h41, t);
    wait_ready(rc);
    check("wr_pulse_count", np - base, 2);
    check("wr_hi_start", p_start[base], t + 3);
    check("wr_lo_start", p_start[base+1], t + 53);
    check("wr_hi_width", p_width[base], P_E);
    check("wr_lo_width", p_width[base+1], P_E);
    check("wr_hi_nib", {28'd0, p_nib[base]}, 32'h4);
    check("wr_lo_nib", {28'd0, p_nib[base+1]}, 32'h1);
    check("wr_rs", {30'd0, p_rs[base], p_rs[base+1]}, 32'h3);
    check("wr_ready_return", rc, t + 1 + P_NIB + P_CMD);

    // Settle time selection: clear/home versus ordinary bytes.
    for (int i = 0; i < 4; i++) begin
      send(wr[i], wd[i], t);
      wait_ready(rc);
      check($sformatf("wait_rs%0d_%0h", wr[i], wd[i]), rc, t + 1 + P_NIB + ww[i]);
    end

    // Back-to-back with req_valid held.
    base = np;
    @(negedge clk);
    req_valid = 1'b1; req_rs = 1'b1; req_data = bb[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 5000) begin @(negedge clk); n++; end
      check($sformatf("b2b%0d_accept", k), {31'd0, req_ready}, 32'd1);
      acc[k] = cyc;
      @(posedge clk); #1;
      if (k < 2) req_data = bb[k+1];
      else       req_valid = 1'b0;
      @(negedge clk);
    end
    wait_ready(rc);
    check("b2b_gap01", acc[1] - acc[0], 1 + P_NIB + P_CMD);
    check("b2b_gap12", acc[2] - acc[1], 1 + P_NIB + P_CMD);
    check("b2b_pulse_count", np - base, 6);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b%0d_bytes", k), {24'd0, p_nib[base+2*k], p_nib[base+2*k+1]}, {24'd0, bb[k]});
    end

    // Reset during the lower-nibble strobe.
    send(1'b1, 8'h96, t);
    n = 0;
    while (cyc < t + 55 && n < 200) begin @(negedge clk); n++; end
    check("mid_E_high", {31'd0, LCD_E}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_E", {31'd0, LCD_E}, 32'd0);
    check("mid_rst_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    base = np;
    n = 0;
    while (np == base && n < P_PWR + 100) begin @(negedge clk); n++; end
    check("reinit_pulse_seen", {31'd0, np > base}, 32'd1);
    check("reinit_start", p_start[base], P_PWR + 2);
    check("reinit_nib", {28'd0, p_nib[base]}, 32'h3);
    check("early_ready", {31'd0, early_ready}, 32'd0);
    check("rw_low", {31'd0, rw_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
